// File: rtl/avg_window_loader_pkg.sv
// Shared types and constants for the averaging-datapath window loader.
//   WINDOW    : samples per window (the averager has exactly eight operands)
//   IDX_W     : width of the fill index into the slot bank
//   DEF_SHIFT : default per-stage shift driven on sa (3 x 1-bit shifts = /8)
//   state_e   : loader FSM states, filling the bank or presenting a window
package avg_window_loader_pkg;

  localparam int unsigned WINDOW    = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned DEF_SHIFT = 1;

  typedef enum logic {
    StFill,
    StPresent
  } state_e;

endpackage

// File: rtl/avg_window_loader_if.sv
// Handshake bundle between the sample producer, the window loader and the
// averager.
//   clear, in_valid, in_data, in_ready      : serial sample input side
//   out_valid, out_ready, a..h, sa          : parallel window output side
//   win_count                               : number of windows handed off
// The slave modport is the loader; the master modport is its environment.
interface avg_window_loader_if #(
  parameter int unsigned DATAWIDTH = 16
) ();

  logic                 clear;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] a, b, c, d, e, f, g, h;
  logic [7:0]           sa;
  logic [15:0]          win_count;

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, a, b, c, d, e, f, g, h, sa, win_count
  );

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, a, b, c, d, e, f, g, h, sa, win_count
  );

endinterface

// File: rtl/avg_window_loader_slot_bank.sv
// Eight-entry sample store plus the registered window presented to the averager.
//   clk, rst : clock and asynchronous active-low reset
//   we       : write wdata into slot[idx] this cycle
//   idx      : fill index
//   wdata    : sample to store
//   load     : snapshot the (write-forwarded) slots into win
//   win      : registered window, win[0] oldest .. win[7] newest
module window_slot_bank
  import avg_window_loader_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [IDX_W-1:0]     idx,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic                 load,
  output logic [DATAWIDTH-1:0] win [WINDOW]
);

  logic [DATAWIDTH-1:0] slot_q [WINDOW];
  logic [DATAWIDTH-1:0] snap   [WINDOW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WINDOW; i++) slot_q[i] <= '0;
    end else if (we) begin
      slot_q[idx] <= wdata;
    end
  end

  // The last sample is written on the same edge as the snapshot, so forward it.
  always_comb begin
    for (int i = 0; i < WINDOW; i++) begin
      snap[i] = (we && (idx == IDX_W'(i))) ? wdata : slot_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WINDOW; i++) win[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < WINDOW; i++) win[i] <= snap[i];
    end
  end

endmodule

// File: rtl/avg_window_loader.sv
// Front end for the 8-input averager: packs eight serial samples into a
// window and hands it off over a valid/ready handshake.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of avg_window_loader_if (sample in, window out,
//          shift amount sa, delivered-window counter win_count)
module avg_window_loader
  import avg_window_loader_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned SHIFT     = DEF_SHIFT
) (
  input  logic               clk,
  input  logic               rst,
  avg_window_loader_if.slave bus
);

  state_e               state_q, state_d;
  logic                 run_q;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [15:0]          win_count_q, win_count_d;
  logic                 in_ready;
  logic                 out_valid;
  logic                 in_xfer;
  logic                 out_xfer;
  logic                 last_sample;
  logic [DATAWIDTH-1:0] win [WINDOW];

  // run_q holds in_ready and sa low for the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StFill;
      run_q       <= 1'b0;
      idx_q       <= '0;
      win_count_q <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      idx_q       <= idx_d;
      win_count_q <= win_count_d;
    end
  end

  // A sample offered alongside clear is dropped, not stored.
  assign in_xfer     = bus.in_valid && in_ready && !bus.clear;
  assign out_xfer    = out_valid && bus.out_ready;
  assign last_sample = in_xfer && (idx_q == IDX_W'(WINDOW - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:    if (last_sample) state_d = StPresent;
      StPresent: if (bus.out_ready) state_d = StFill;
      default:   state_d = StFill;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StFill:    in_ready  = run_q;
      StPresent: out_valid = 1'b1;
      default:   ;
    endcase
  end

  // idx wraps 7 -> 0 naturally on the last sample.
  always_comb begin
    idx_d = idx_q;
    if (state_q == StFill) begin
      if (bus.clear) idx_d = '0;
      else if (in_xfer) idx_d = idx_q + 1'b1;
    end
  end

  always_comb begin
    win_count_d = win_count_q;
    if (out_xfer) win_count_d = win_count_q + 16'd1;
  end

  window_slot_bank #(
    .DATAWIDTH (DATAWIDTH)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (in_xfer),
    .idx   (idx_q),
    .wdata (bus.in_data),
    .load  (last_sample),
    .win   (win)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.a         = win[0];
  assign bus.b         = win[1];
  assign bus.c         = win[2];
  assign bus.d         = win[3];
  assign bus.e         = win[4];
  assign bus.f         = win[5];
  assign bus.g         = win[6];
  assign bus.h         = win[7];
  assign bus.sa        = run_q ? 8'(SHIFT) : 8'd0;
  assign bus.win_count = win_count_q;

endmodule

// File: tb/tb_avg_window_loader.sv
// Self-checking bench for avg_window_loader: directed scenarios plus random
// traffic, all compared against a queue-based model of the window rules.
module tb_avg_window_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  avg_window_loader_if #(.DATAWIDTH(16)) bus ();

  avg_window_loader #(
    .DATAWIDTH (16),
    .SHIFT     (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] act [8];
  assign act[0] = bus.a;
  assign act[1] = bus.b;
  assign act[2] = bus.c;
  assign act[3] = bus.d;
  assign act[4] = bus.e;
  assign act[5] = bus.f;
  assign act[6] = bus.g;
  assign act[7] = bus.h;

  int ncmp = 0;
  int nerr = 0;

  // Reference model: accepted samples queue up; eight make a window.
  bit          m_run;
  bit          m_present;
  logic [15:0] m_q [$];
  logic [15:0] m_win [8];
  logic [15:0] m_count;

  task automatic model_reset();
    m_run     = 1'b0;
    m_present = 1'b0;
    m_q.delete();
    for (int i = 0; i < 8; i++) m_win[i] = 16'd0;
    m_count = 16'd0;
  endtask

  // One clock: drive at the negedge, update the model at the posedge,
  // return at the following negedge with DUT outputs settled.
  task automatic cycle(input logic v, input logic [15:0] d, input logic ordy, input logic clr);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.clear     = clr;
    @(posedge clk);
    if (!m_run) begin
      m_run = 1'b1;
    end else if (m_present) begin
      if (ordy) begin
        m_present = 1'b0;
        m_count   = m_count + 16'd1;
      end
    end else if (clr) begin
      m_q.delete();
    end else if (v) begin
      m_q.push_back(d);
      if (m_q.size() == 8) begin
        for (int i = 0; i < 8; i++) m_win[i] = m_q[i];
        m_q.delete();
        m_present = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic init_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'd0;
    bus.out_ready = 1'b0;
    bus.clear     = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) begin
      ncmp++;
      if (bus.out_valid !== 1'b0) begin
        nerr++;
        $display("FAIL basic_early_valid: got %0b want 0 (sample %0d)", bus.out_valid, i);
      end
      cycle(1'b1, 16'(i + 1), 1'b1, 1'b0);
    end
    ncmp++;
    if (bus.out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL basic_valid: got %0b want 1", bus.out_valid);
    end
    ncmp++;
    if (bus.in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL basic_in_ready: got %0b want 0", bus.in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      ncmp++;
      if (act[i] !== 16'(i + 1)) begin
        nerr++;
        $display("FAIL basic_operand[%0d]: got %0d want %0d", i, act[i], i + 1);
      end
    end
    // Cascaded pairwise average with shift sa at each of three stages.
    begin
      logic [16:0] s1 [4];
      logic [16:0] s2 [2];
      logic [16:0] avg;
      for (int i = 0; i < 4; i++) s1[i] = ({1'b0, act[2*i]} + {1'b0, act[2*i+1]}) >> bus.sa;
      for (int i = 0; i < 2; i++) s2[i] = (s1[2*i] + s1[2*i+1]) >> bus.sa;
      avg = (s2[0] + s2[1]) >> bus.sa;
      ncmp++;
      if (avg !== 17'd4) begin
        nerr++;
        $display("FAIL basic_avg: got %0d want 4", avg);
      end
    end
    cycle(1'b1, 16'd99, 1'b1, 1'b0);
    ncmp++;
    if (bus.out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL basic_valid_drop: got %0b want 0", bus.out_valid);
    end
    ncmp++;
    if (bus.win_count !== 16'd1) begin
      nerr++;
      $display("FAIL basic_count: got %0d want 1", bus.win_count);
    end
  endtask

  task automatic check_in_reset(input string tag);
    ncmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL %s_hs: got valid=%0b ready=%0b want 0 0", tag, bus.out_valid, bus.in_ready);
    end
    ncmp++;
    if (bus.win_count !== 16'd0 || bus.sa !== 8'd0) begin
      nerr++;
      $display("FAIL %s_cnt_sa: got count=%0d sa=%0d want 0 0", tag, bus.win_count, bus.sa);
    end
    for (int i = 0; i < 8; i++) begin
      ncmp++;
      if (act[i] !== 16'd0) begin
        nerr++;
        $display("FAIL %s_operand[%0d]: got %h want 0", tag, i, act[i]);
      end
    end
  endtask

  task automatic test_reset();
    // Mid-window reset, while a nonzero window is still on a..h.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'(50 + i), 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 check_in_reset("rst_fill");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    ncmp++;
    if (bus.in_ready !== 1'b0 || bus.sa !== 8'd0) begin
      nerr++;
      $display("FAIL rst_release_pre: got ready=%0b sa=%0d want 0 0", bus.in_ready, bus.sa);
    end
    cycle(1'b0, 16'd0, 1'b0, 1'b0);
    ncmp++;
    if (bus.in_ready !== 1'b1 || bus.sa !== 8'd1) begin
      nerr++;
      $display("FAIL rst_release_post: got ready=%0b sa=%0d want 1 1", bus.in_ready, bus.sa);
    end
    // Reset while a window is being presented.
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'(200 + i), 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 check_in_reset("rst_present");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [15:0] d;
    for (int i = 0; i < 8; i++) begin
      d = 16'($urandom);
      cycle(1'b1, d, 1'b0, 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      cycle(k == 2, 16'hDEAD, 1'b0, 1'b0);
      ncmp++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL bp_hold_hs: got valid=%0b ready=%0b want 1 0", bus.out_valid, bus.in_ready);
      end
      for (int i = 0; i < 8; i++) begin
        ncmp++;
        if (act[i] !== m_win[i]) begin
          nerr++;
          $display("FAIL bp_hold_operand[%0d]: got %h want %h", i, act[i], m_win[i]);
        end
      end
    end
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    ncmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.win_count !== m_count) begin
      nerr++;
      $display("FAIL bp_release: got valid=%0b ready=%0b count=%0d want 0 1 %0d",
               bus.out_valid, bus.in_ready, bus.win_count, m_count);
    end
    for (int i = 0; i < 8; i++) begin
      d = 16'($urandom);
      cycle(1'b1, d, 1'b0, 1'b0);
    end
    ncmp++;
    if (bus.out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL bp_next_valid: got %0b want 1", bus.out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      ncmp++;
      if (act[i] !== m_win[i]) begin
        nerr++;
        $display("FAIL bp_next_operand[%0d]: got %h want %h", i, act[i], m_win[i]);
      end
    end
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
  endtask

  task automatic test_clear();
    cycle(1'b1, 16'd10, 1'b0, 1'b0);
    cycle(1'b1, 16'd20, 1'b0, 1'b0);
    cycle(1'b1, 16'd30, 1'b0, 1'b0);
    cycle(1'b1, 16'd999, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'(100 * (i + 1)), 1'b0, 1'b0);
    ncmp++;
    if (bus.out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL clr_valid: got %0b want 1", bus.out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      ncmp++;
      if (act[i] !== 16'(100 * (i + 1))) begin
        nerr++;
        $display("FAIL clr_operand[%0d]: got %0d want %0d", i, act[i], 100 * (i + 1));
      end
    end
    cycle(1'b1, 16'd7, 1'b0, 1'b1);
    ncmp++;
    if (bus.out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL clr_present_valid: got %0b want 1", bus.out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      ncmp++;
      if (act[i] !== 16'(100 * (i + 1))) begin
        nerr++;
        $display("FAIL clr_present_operand[%0d]: got %0d want %0d", i, act[i], 100 * (i + 1));
      end
    end
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
  endtask

  task automatic test_gapped();
    int guard = 0;
    logic v;
    while (!m_present && guard < 200) begin
      ncmp++;
      if (bus.out_valid !== 1'b0) begin
        nerr++;
        $display("FAIL gap_early_valid: got %0b want 0 (have %0d)", bus.out_valid, m_q.size());
      end
      v = 1'($urandom_range(0, 1));
      cycle(v, 16'hFFFF, 1'b0, 1'b0);
      guard++;
    end
    ncmp++;
    if (!m_present) begin
      nerr++;
      $display("FAIL gap_timeout: got %0d samples want 8", m_q.size());
    end
    ncmp++;
    if (bus.out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL gap_latency: got valid=%0b want 1 one clock after 8th", bus.out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      ncmp++;
      if (act[i] !== 16'hFFFF) begin
        nerr++;
        $display("FAIL gap_operand[%0d]: got %h want ffff", i, act[i]);
      end
    end
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic v, ordy, clr;
    logic [15:0] d;
    for (int n = 0; n < 400; n++) begin
      v    = 1'($urandom_range(0, 3) != 0);
      ordy = 1'($urandom_range(0, 1));
      clr  = 1'($urandom_range(0, 15) == 0);
      d    = 16'($urandom);
      cycle(v, d, ordy, clr);
      ncmp++;
      if (bus.out_valid !== m_present || bus.in_ready !== (m_run && !m_present) ||
          bus.win_count !== m_count) begin
        nerr++;
        $display("FAIL rand_ctrl@%0d: got v=%0b r=%0b c=%0d want %0b %0b %0d", n,
                 bus.out_valid, bus.in_ready, bus.win_count, m_present,
                 m_run && !m_present, m_count);
      end
      for (int i = 0; i < 8; i++) begin
        ncmp++;
        if (act[i] !== m_win[i]) begin
          nerr++;
          $display("FAIL rand_operand[%0d]@%0d: got %h want %h", i, n, act[i], m_win[i]);
        end
      end
    end
    cycle(1'b0, 16'd0, 1'b1, 1'b1);
  endtask

  task automatic test_wrap();
    logic [15:0] d;
    // Held across one idle edge so the register itself captures 16'hFFFF.
    force dut.win_count_q = 16'hFFFF;
    cycle(1'b0, 16'd0, 1'b0, 1'b0);
    release dut.win_count_q;
    m_count = 16'hFFFF;
    ncmp++;
    if (bus.win_count !== 16'hFFFF) begin
      nerr++;
      $display("FAIL wrap_preload: got %h want ffff", bus.win_count);
    end
    for (int i = 0; i < 8; i++) begin
      d = 16'($urandom);
      cycle(1'b1, d, 1'b0, 1'b0);
    end
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    ncmp++;
    if (bus.win_count !== m_count || bus.win_count !== 16'd0) begin
      nerr++;
      $display("FAIL wrap_count: got %h want 0000", bus.win_count);
    end
  endtask

  initial begin
    init_reset();
    test_basic();
    test_reset();
    test_backpressure();
    test_clear();
    test_gapped();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
